// File: rtl/gt_common_pkg.sv
// Shared PLL bank definitions: channel state encoding,
// DRP register map and bus widths.
package gt_common_pkg;

   localparam int DRP_AW = 8;
   localparam int DRP_DW = 16;

   typedef enum logic [1:0] {
      PLL_OFF    = 2'd0,
      PLL_ACQ    = 2'd1,
      PLL_LOCKED = 2'd2,
      PLL_LOST   = 2'd3
   } pll_state_e;

   localparam logic [3:0] REG_FBDIV   = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h1;
   localparam logic [3:0] REG_LOCKCNT = 4'h2;
   localparam logic [3:0] REG_SCRATCH = 4'h3;

endpackage

// File: rtl/gt_pll_chan.sv
// One PLL channel: lock FSM, lock counter, refclk
// watchdog and feedback divider clock-enable.
module gt_pll_chan
   import gt_common_pkg::*;
#(
   parameter int LOCK_CYCLES  = 100,
   parameter int LOST_TIMEOUT = 64
) (
   input  logic       DRPCLK,
   input  logic       RESET,
   input  logic       pllreset,
   input  logic       pllpd,
   input  logic       locken,
   input  logic       refclkvalid,
   input  logic [7:0] fbdiv,
   input  logic       div_clr,
   output pll_state_e state,
   output logic [7:0] lock_cnt,
   output logic       lock,
   output logic       refclklost,
   output logic       outce
);

   localparam logic [7:0] LCK = 8'(LOCK_CYCLES);
   localparam logic [7:0] TMO = 8'(LOST_TIMEOUT);

   pll_state_e st_n;
   logic [7:0] lc_n, div_cnt, dc_n, wd, wd_n, wd_inc;
   logic       lost_n, oce_n;

   always_comb begin
      st_n   = state;
      lc_n   = lock_cnt;
      dc_n   = div_cnt;
      wd_n   = wd;
      lost_n = refclklost;
      oce_n  = 1'b0;
      wd_inc = wd + 8'd1;
      unique case (state)
         PLL_OFF: begin
            lc_n   = '0;
            dc_n   = '0;
            wd_n   = '0;
            lost_n = 1'b1;
            if (locken) st_n = PLL_ACQ;
         end
         PLL_ACQ: begin
            if (refclkvalid) begin
               wd_n   = '0;
               lost_n = 1'b0;
               if (locken) begin
                  if (lock_cnt != 8'hFF) lc_n = lock_cnt + 8'd1;
                  if (lc_n == LCK) st_n = PLL_LOCKED;
               end
            end else if (wd_inc == TMO) begin
               st_n   = PLL_LOST;
               lc_n   = '0;
               dc_n   = '0;
               wd_n   = '0;
               lost_n = 1'b1;
            end else begin
               wd_n = wd_inc;
            end
         end
         PLL_LOCKED: begin
            if (refclkvalid) begin
               wd_n = '0;
               if (div_cnt + 8'd1 >= fbdiv) begin
                  oce_n = 1'b1;
                  dc_n  = '0;
               end else begin
                  dc_n = div_cnt + 8'd1;
               end
            end else if (wd_inc == TMO) begin
               st_n   = PLL_LOST;
               lc_n   = '0;
               dc_n   = '0;
               wd_n   = '0;
               lost_n = 1'b1;
            end else begin
               wd_n = wd_inc;
            end
         end
         PLL_LOST: begin
            if (refclkvalid) begin
               st_n   = PLL_ACQ;
               lc_n   = 8'd1;
               wd_n   = '0;
               lost_n = 1'b0;
            end
         end
         default: st_n = PLL_OFF;
      endcase
      if (div_clr) dc_n = '0;
      // Reset and power-down override every other event.
      if (pllreset || pllpd) begin
         st_n   = PLL_OFF;
         lc_n   = '0;
         dc_n   = '0;
         wd_n   = '0;
         lost_n = 1'b1;
         oce_n  = 1'b0;
      end
   end

   always_ff @(posedge DRPCLK) begin
      if (RESET) begin
         state      <= PLL_OFF;
         lock_cnt   <= '0;
         div_cnt    <= '0;
         wd         <= '0;
         lock       <= 1'b0;
         refclklost <= 1'b1;
         outce      <= 1'b0;
      end else begin
         state      <= st_n;
         lock_cnt   <= lc_n;
         div_cnt    <= dc_n;
         wd         <= wd_n;
         lock       <= (st_n == PLL_LOCKED);
         refclklost <= lost_n;
         outce      <= oce_n;
      end
   end

endmodule

// File: rtl/gt_pll_bank.sv
// Bank of PLL channels with a shared DRP port holding
// per-channel divider, status, lock count and scratch.
module gt_pll_bank
   import gt_common_pkg::*;
#(
   parameter int N_PLL        = 2,
   parameter int LOCK_CYCLES  = 100,
   parameter int LOST_TIMEOUT = 64,
   parameter int FBDIV_INIT   = 4
) (
   input  logic              DRPCLK,
   input  logic              RESET,
   input  logic [N_PLL-1:0]  PLLRESET,
   input  logic [N_PLL-1:0]  PLLPD,
   input  logic [N_PLL-1:0]  PLLLOCKEN,
   input  logic [N_PLL-1:0]  REFCLKVALID,
   output logic [N_PLL-1:0]  PLLLOCK,
   output logic [N_PLL-1:0]  PLLREFCLKLOST,
   output logic [N_PLL-1:0]  PLLOUTCE,
   input  logic              DRPEN,
   input  logic              DRPWE,
   input  logic [DRP_AW-1:0] DRPADDR,
   input  logic [DRP_DW-1:0] DRPDI,
   output logic [DRP_DW-1:0] DRPDO,
   output logic              DRPRDY
);

   logic [7:0]        fbdiv_q   [N_PLL];
   logic [15:0]       scratch_q [N_PLL];
   pll_state_e        st_w      [N_PLL];
   logic [7:0]        lc_w      [N_PLL];
   logic [N_PLL-1:0]  fb_wr, sc_wr;
   logic [DRP_DW-1:0] rd_data;
   logic [3:0]        ch, rg;
   logic              accept, wr;
   logic [7:0]        fb_wdata;

   assign ch       = DRPADDR[7:4];
   assign rg       = DRPADDR[3:0];
   assign accept   = DRPEN && !DRPRDY;
   assign wr       = accept && DRPWE;
   assign fb_wdata = (DRPDI[7:0] == 8'd0) ? 8'd1 : DRPDI[7:0];

   // Unmatched channel or offset leaves read data at 0 and no write strobe.
   always_comb begin
      rd_data = '0;
      fb_wr   = '0;
      sc_wr   = '0;
      for (int i = 0; i < N_PLL; i++) begin
         if (ch == 4'(i)) begin
            unique case (rg)
               REG_FBDIV: begin
                  rd_data  = {8'b0, fbdiv_q[i]};
                  fb_wr[i] = wr;
               end
               REG_STATUS:
                  rd_data = {12'b0, PLLLOCK[i], PLLREFCLKLOST[i], st_w[i]};
               REG_LOCKCNT:
                  rd_data = {8'b0, lc_w[i]};
               REG_SCRATCH: begin
                  rd_data  = scratch_q[i];
                  sc_wr[i] = wr;
               end
               default: rd_data = '0;
            endcase
         end
      end
   end

   always_ff @(posedge DRPCLK) begin
      if (RESET) begin
         DRPRDY <= 1'b0;
         DRPDO  <= '0;
         for (int i = 0; i < N_PLL; i++) begin
            fbdiv_q[i]   <= 8'(FBDIV_INIT);
            scratch_q[i] <= '0;
         end
      end else begin
         DRPRDY <= accept;
         if (accept) DRPDO <= DRPWE ? '0 : rd_data;
         for (int i = 0; i < N_PLL; i++) begin
            if (fb_wr[i]) fbdiv_q[i]   <= fb_wdata;
            if (sc_wr[i]) scratch_q[i] <= DRPDI;
         end
      end
   end

   for (genvar g = 0; g < N_PLL; g++) begin : g_chan
      gt_pll_chan #(
         .LOCK_CYCLES  (LOCK_CYCLES),
         .LOST_TIMEOUT (LOST_TIMEOUT)
      ) u_chan (
         .DRPCLK      (DRPCLK),
         .RESET       (RESET),
         .pllreset    (PLLRESET[g]),
         .pllpd       (PLLPD[g]),
         .locken      (PLLLOCKEN[g]),
         .refclkvalid (REFCLKVALID[g]),
         .fbdiv       (fbdiv_q[g]),
         .div_clr     (fb_wr[g]),
         .state       (st_w[g]),
         .lock_cnt    (lc_w[g]),
         .lock        (PLLLOCK[g]),
         .refclklost  (PLLREFCLKLOST[g]),
         .outce       (PLLOUTCE[g])
      );
   end

endmodule

// File: tb/tb_gt_pll_bank.sv
// Directed scoreboard bench for gt_pll_bank: DRP reads queue
// their expected data, a negedge monitor pops on DRPRDY.
module tb_gt_pll_bank;

   localparam int N = 2;

   logic         DRPCLK = 1'b0;
   logic         RESET  = 1'b1;
   logic [N-1:0] PLLRESET = '0, PLLPD = '0, PLLLOCKEN = '0, REFCLKVALID = '0;
   logic [N-1:0] PLLLOCK, PLLREFCLKLOST, PLLOUTCE;
   logic         DRPEN = 1'b0, DRPWE = 1'b0;
   logic [7:0]   DRPADDR = '0;
   logic [15:0]  DRPDI = '0;
   logic [15:0]  DRPDO;
   logic         DRPRDY;

   int tests = 0, failed = 0, rdy_cnt = 0;
   logic [15:0] exp_q[$];

   gt_pll_bank #(.N_PLL(N)) dut (
      .DRPCLK        (DRPCLK),
      .RESET         (RESET),
      .PLLRESET      (PLLRESET),
      .PLLPD         (PLLPD),
      .PLLLOCKEN     (PLLLOCKEN),
      .REFCLKVALID   (REFCLKVALID),
      .PLLLOCK       (PLLLOCK),
      .PLLREFCLKLOST (PLLREFCLKLOST),
      .PLLOUTCE      (PLLOUTCE),
      .DRPEN         (DRPEN),
      .DRPWE         (DRPWE),
      .DRPADDR       (DRPADDR),
      .DRPDI         (DRPDI),
      .DRPDO         (DRPDO),
      .DRPRDY        (DRPRDY)
   );

   always #5 DRPCLK = ~DRPCLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor
   initial begin
      forever begin
         @(negedge DRPCLK);
         if (DRPRDY === 1'b1) begin
            rdy_cnt++;
            if (exp_q.size() == 0) begin
               chk("drprdy_unexpected", 32'(DRPDO), 32'hFFFF_FFFF);
            end else begin
               chk("drpdo", 32'(DRPDO), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge DRPCLK);
   endtask

   task automatic drp(input logic [7:0] a, input logic we,
                      input logic [15:0] d, input logic [15:0] e);
      DRPEN = 1'b1; DRPWE = we; DRPADDR = a; DRPDI = d;
      exp_q.push_back(we ? 16'h0 : e);
      @(negedge DRPCLK);
      DRPEN = 1'b0; DRPWE = 1'b0;
      @(negedge DRPCLK);
   endtask

   task automatic strobe(input int c, input int n);
      repeat (n) begin
         REFCLKVALID[c] = 1'b1;
         @(negedge DRPCLK);
         REFCLKVALID[c] = 1'b0;
         @(negedge DRPCLK);
      end
   endtask

   task automatic strobe_oce(input int c, input logic e);
      REFCLKVALID[c] = 1'b1;
      @(negedge DRPCLK);
      chk("outce", 32'(PLLOUTCE[c]), 32'(e));
      REFCLKVALID[c] = 1'b0;
      @(negedge DRPCLK);
      chk("outce_gap", 32'(PLLOUTCE[c]), 32'h0);
   endtask

   int rc0;

   initial begin
      tick(3);
      chk("rst_lock", 32'(PLLLOCK), 32'h0);
      chk("rst_lost", 32'(PLLREFCLKLOST), 32'h3);
      chk("rst_outce", 32'(PLLOUTCE), 32'h0);
      chk("rst_rdy", 32'(DRPRDY), 32'h0);
      chk("rst_do", 32'(DRPDO), 32'h0);
      RESET = 1'b0;
      tick(1);
      drp(8'h00, 1'b0, 16'h0, 16'h0004);
      drp(8'h03, 1'b0, 16'h0, 16'h0000);
      drp(8'h01, 1'b0, 16'h0, 16'h0004);

      // Acquire and lock channel 0
      PLLLOCKEN = 2'b01;
      tick(1);
      drp(8'h01, 1'b0, 16'h0, 16'h0005);
      strobe(0, 99);
      chk("lock_before_100", 32'(PLLLOCK[0]), 32'h0);
      REFCLKVALID[0] = 1'b1;
      @(negedge DRPCLK);
      REFCLKVALID[0] = 1'b0;
      chk("lock_after_100", 32'(PLLLOCK[0]), 32'h1);
      @(negedge DRPCLK);
      drp(8'h01, 1'b0, 16'h0, 16'h000A);
      drp(8'h02, 1'b0, 16'h0, 16'h0064);

      // Divider: FBDIV=4, then write 0 -> stores 1
      for (int k = 1; k <= 8; k++) strobe_oce(0, (k % 4) == 0);
      drp(8'h00, 1'b1, 16'h0000, 16'h0);
      drp(8'h00, 1'b0, 16'h0, 16'h0001);
      for (int k = 0; k < 3; k++) strobe_oce(0, 1'b1);

      // Watchdog
      tick(62);
      chk("lock_at_63", 32'(PLLLOCK[0]), 32'h1);
      tick(1);
      chk("lock_at_64", 32'(PLLLOCK[0]), 32'h0);
      chk("lost_at_64", 32'(PLLREFCLKLOST[0]), 32'h1);
      drp(8'h01, 1'b0, 16'h0, 16'h0007);
      drp(8'h02, 1'b0, 16'h0, 16'h0000);
      strobe(0, 1);
      drp(8'h01, 1'b0, 16'h0, 16'h0001);
      drp(8'h02, 1'b0, 16'h0, 16'h0001);

      // Relock, then power-down pulse
      strobe(0, 99);
      chk("relock", 32'(PLLLOCK[0]), 32'h1);
      PLLPD[0] = 1'b1;
      @(negedge DRPCLK);
      PLLPD[0] = 1'b0;
      chk("pd_lock", 32'(PLLLOCK[0]), 32'h0);
      chk("pd_lost", 32'(PLLREFCLKLOST[0]), 32'h1);
      drp(8'h02, 1'b0, 16'h0, 16'h0000);
      drp(8'h01, 1'b0, 16'h0, 16'h0005);
      strobe(0, 99);
      chk("pd_relock_99", 32'(PLLLOCK[0]), 32'h0);
      strobe(0, 1);
      chk("pd_relock_100", 32'(PLLLOCK[0]), 32'h1);

      // DRPEN held 4 cycles -> 2 transactions
      drp(8'h13, 1'b1, 16'hBEEF, 16'h0);
      drp(8'h13, 1'b0, 16'h0, 16'hBEEF);
      rc0 = rdy_cnt;
      exp_q.push_back(16'hBEEF);
      exp_q.push_back(16'hBEEF);
      DRPEN = 1'b1; DRPWE = 1'b0; DRPADDR = 8'h13;
      tick(4);
      DRPEN = 1'b0;
      tick(1);
      chk("held_rdy_pulses", 32'(rdy_cnt - rc0), 32'd2);

      // Out-of-range addresses
      drp(8'h50, 1'b0, 16'h0, 16'h0000);
      drp(8'h13, 1'b0, 16'h0, 16'hBEEF);
      drp(8'h04, 1'b0, 16'h0, 16'h0000);
      drp(8'h04, 1'b1, 16'h1234, 16'h0);
      drp(8'h53, 1'b1, 16'h1234, 16'h0);
      drp(8'h03, 1'b0, 16'h0, 16'h0000);

      // Write coinciding with channel reset
      PLLRESET[1] = 1'b1;
      drp(8'h10, 1'b1, 16'h0007, 16'h0);
      PLLRESET[1] = 1'b0;
      drp(8'h10, 1'b0, 16'h0, 16'h0007);
      drp(8'h11, 1'b0, 16'h0, 16'h0004);

      // Reset on the accept edge drops DRPRDY
      DRPEN = 1'b1; DRPWE = 1'b0; DRPADDR = 8'h13;
      RESET = 1'b1;
      @(negedge DRPCLK);
      DRPEN = 1'b0;
      chk("rst_drop_rdy", 32'(DRPRDY), 32'h0);
      chk("rst_drop_lock", 32'(PLLLOCK), 32'h0);
      RESET = 1'b0;
      tick(1);
      drp(8'h10, 1'b0, 16'h0, 16'h0004);
      drp(8'h13, 1'b0, 16'h0, 16'h0000);

      tick(2);
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
